// File: rtl/retire_trace_fifo.sv
// rtl/retire_trace_fifo.sv - pairs retire events with GPR write-backs into trace records
// Records sit in a DEPTH-entry FIFO and leave over a valid/ready port; overflow drops are counted.
module retire_trace_fifo #(
  parameter int DEPTH    = 4,
  parameter int WB_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic [31:0] retire_pc,
  input  logic [31:0] psr,
  input  logic        wb_gpr_en,
  input  logic [4:0]  wb_gpr_index,
  input  logic [31:0] wb_gpr_data,
  input  logic        clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_psr,
  output logic        out_wb_en,
  output logic [4:0]  out_wb_index,
  output logic [31:0] out_wb_data,
  output logic        out_wb_only,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [31:0] retire_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 103;

  logic          w_enq;
  logic [31:0]   w_rec_pc;
  logic [31:0]   w_rec_psr;
  logic          w_rec_wbo;
  logic [RW-1:0] w_rec;
  logic [RW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [RW-1:0] r_mem [DEPTH];
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;
  logic [31:0]   r_retire_cnt;

  generate
    if (WB_DELAY == 0) begin : g_direct
      assign w_enq     = retire | wb_gpr_en;
      assign w_rec_pc  = retire ? retire_pc : 32'd0;
      assign w_rec_psr = retire ? psr : 32'd0;
      assign w_rec_wbo = ~retire;
    end else begin : g_staged
      // Stage holds last cycle's retire so it can meet its write-back one cycle later.
      logic        r_stg_v;
      logic [31:0] r_stg_pc;
      logic [31:0] r_stg_psr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stg_v   <= 1'b0;
          r_stg_pc  <= 32'd0;
          r_stg_psr <= 32'd0;
        end else begin
          r_stg_v <= retire;
          if (retire) begin
            r_stg_pc  <= retire_pc;
            r_stg_psr <= psr;
          end
        end
      end

      assign w_enq     = r_stg_v | wb_gpr_en;
      assign w_rec_pc  = r_stg_v ? r_stg_pc : 32'd0;
      assign w_rec_psr = r_stg_v ? r_stg_psr : 32'd0;
      assign w_rec_wbo = ~r_stg_v;
    end
  endgenerate

  assign w_rec = {w_rec_wbo,
                  wb_gpr_en & (wb_gpr_index != 5'd0),
                  wb_gpr_en ? wb_gpr_index : 5'd0,
                  wb_gpr_en ? wb_gpr_data : 32'd0,
                  w_rec_psr,
                  w_rec_pc};

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_enq & (~w_full | w_pop);
  assign w_drop  = w_enq & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_cnt   <= 16'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clr) begin
          r_drop_cnt <= 16'd1;
        end else if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (clr) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= 16'd0;
      end
      if (retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  assign w_head       = r_mem[r_rptr[AW-1:0]];
  assign out_valid    = ~w_empty;
  assign out_pc       = out_valid ? w_head[31:0]   : 32'd0;
  assign out_psr      = out_valid ? w_head[63:32]  : 32'd0;
  assign out_wb_data  = out_valid ? w_head[95:64]  : 32'd0;
  assign out_wb_index = out_valid ? w_head[100:96] : 5'd0;
  assign out_wb_en    = out_valid & w_head[101];
  assign out_wb_only  = out_valid & w_head[102];
  assign overflow     = r_overflow;
  assign drop_cnt     = r_drop_cnt;
  assign retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb/tb_retire_trace_fifo.sv - scoreboard bench for both pairing modes of retire_trace_fifo
module tb_retire_trace_fifo;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] psr;
    logic        wb_en;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        wbo;
    logic        has_wb;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] psr = '0;
  logic        wb_gpr_en = 1'b0;
  logic [4:0]  wb_gpr_index = '0;
  logic [31:0] wb_gpr_data = '0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        v0, wbe0, wbo0, ovf0;
  logic [31:0] pc0, psr0, dt0, rc0;
  logic [4:0]  ix0;
  logic [15:0] dc0;
  logic        v1, wbe1, wbo1, ovf1;
  logic [31:0] pc1, psr1, dt1, rc1;
  logic [4:0]  ix1;
  logic [15:0] dc1;

  int n_checks = 0;
  int n_errors = 0;

  rec_t        q0[$];
  rec_t        q1[$];
  bit          st_v = 1'b0;
  logic [31:0] st_pc = '0;
  logic [31:0] st_psr = '0;
  logic        ovf_m [2] = '{1'b0, 1'b0};
  int          drop_m [2] = '{0, 0};
  logic [31:0] rcnt_m [2] = '{32'd0, 32'd0};

  always #5 clk = ~clk;

  retire_trace_fifo #(.DEPTH(DEPTH), .WB_DELAY(0)) u0 (
    .clk(clk), .rst(rst), .retire(retire), .retire_pc(retire_pc), .psr(psr),
    .wb_gpr_en(wb_gpr_en), .wb_gpr_index(wb_gpr_index), .wb_gpr_data(wb_gpr_data),
    .clr(clr), .out_valid(v0), .out_ready(out_ready), .out_pc(pc0), .out_psr(psr0),
    .out_wb_en(wbe0), .out_wb_index(ix0), .out_wb_data(dt0), .out_wb_only(wbo0),
    .overflow(ovf0), .drop_cnt(dc0), .retire_cnt(rc0)
  );

  retire_trace_fifo #(.DEPTH(DEPTH), .WB_DELAY(1)) u1 (
    .clk(clk), .rst(rst), .retire(retire), .retire_pc(retire_pc), .psr(psr),
    .wb_gpr_en(wb_gpr_en), .wb_gpr_index(wb_gpr_index), .wb_gpr_data(wb_gpr_data),
    .clr(clr), .out_valid(v1), .out_ready(out_ready), .out_pc(pc1), .out_psr(psr1),
    .out_wb_en(wbe1), .out_wb_index(ix1), .out_wb_data(dt1), .out_wb_only(wbo1),
    .overflow(ovf1), .drop_cnt(dc1), .retire_cnt(rc1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input bit has, input logic [31:0] pc, input logic [31:0] ps);
    rec_t r;
    r.pc     = has ? pc : 32'd0;
    r.psr    = has ? ps : 32'd0;
    r.wbo    = !has;
    r.has_wb = wb_gpr_en;
    r.wb_en  = wb_gpr_en && (wb_gpr_index != 5'd0);
    r.idx    = wb_gpr_index;
    r.data   = wb_gpr_data;
    return r;
  endfunction

  task automatic bump(input int d, input bit dropped);
    if (clr) begin
      ovf_m[d]  = 1'b0;
      drop_m[d] = 0;
    end
    if (dropped) begin
      ovf_m[d] = 1'b1;
      if (drop_m[d] < 65535) drop_m[d]++;
    end
    if (retire) rcnt_m[d] = rcnt_m[d] + 32'd1;
  endtask

  // Reference model: builds each cycle's record from the pairing rules, drops when the queue is full.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q0.delete();
      q1.delete();
      st_v = 1'b0;
      for (int d = 0; d < 2; d++) begin
        ovf_m[d] = 1'b0; drop_m[d] = 0; rcnt_m[d] = 32'd0;
      end
    end else begin
      rec_t r;
      bit e, dr;
      e  = retire || wb_gpr_en;
      r  = mk(retire, retire_pc, psr);
      dr = e && (q0.size() == DEPTH);
      if (e && !dr) q0.push_back(r);
      bump(0, dr);
      e  = st_v || wb_gpr_en;
      r  = mk(st_v, st_pc, st_psr);
      dr = e && (q1.size() == DEPTH);
      if (e && !dr) q1.push_back(r);
      bump(1, dr);
      st_v   = retire;
      st_pc  = retire_pc;
      st_psr = psr;
    end
  end

  task automatic mon(input int d, input logic v, input logic [31:0] pc, input logic [31:0] ps,
                     input logic wbe, input logic [4:0] ix, input logic [31:0] dt, input logic wbo,
                     input logic ovf, input logic [15:0] dc, input logic [31:0] rc);
    rec_t  e;
    int    sz;
    string p;
    p  = $sformatf("u%0d", d);
    sz = (d == 0) ? q0.size() : q1.size();
    chk({p, ".out_valid"}, 32'(v), 32'(sz != 0));
    if (sz != 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      chk({p, ".out_pc"}, pc, e.pc);
      chk({p, ".out_psr"}, ps, e.psr);
      chk({p, ".out_wb_en"}, 32'(wbe), 32'(e.wb_en));
      chk({p, ".out_wb_only"}, 32'(wbo), 32'(e.wbo));
      if (e.has_wb) begin
        chk({p, ".out_wb_index"}, 32'(ix), 32'(e.idx));
        chk({p, ".out_wb_data"}, dt, e.data);
      end
      if (out_ready) begin
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end else begin
      chk({p, ".idle_pc"}, pc, 32'd0);
      chk({p, ".idle_data"}, dt, 32'd0);
    end
    chk({p, ".overflow"}, 32'(ovf), 32'(ovf_m[d]));
    chk({p, ".drop_cnt"}, 32'(dc), 32'(drop_m[d]));
    chk({p, ".retire_cnt"}, rc, rcnt_m[d]);
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mon(0, v0, pc0, psr0, wbe0, ix0, dt0, wbo0, ovf0, dc0, rc0);
      mon(1, v1, pc1, psr1, wbe1, ix1, dt1, wbo1, ovf1, dc1, rc1);
    end
  end

  task automatic cyc(input bit rt, input logic [31:0] pc, input logic [31:0] ps, input bit we,
                     input logic [4:0] ix, input logic [31:0] dt, input bit rdy, input bit cl);
    retire = rt; retire_pc = pc; psr = ps;
    wb_gpr_en = we; wb_gpr_index = ix; wb_gpr_data = dt;
    out_ready = rdy; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset.u0.out_valid", 32'(v0), 32'd0);
    chk("reset.u1.out_valid", 32'(v1), 32'd0);
    chk("reset.u0.retire_cnt", rc0, 32'd0);
    chk("reset.u0.drop_cnt", 32'(dc0), 32'd0);
    chk("reset.u0.overflow", 32'(ovf0), 32'd0);
    chk("reset.u0.out_pc", pc0, 32'd0);
    rst = 1'b0;

    cyc(1'b1, 32'h8000_0000, 32'h1800, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("single.u0.latency", 32'(v0), 32'd1);
    chk("single.u0.retire_cnt", rc0, 32'd1);
    idle(3, 1'b1);

    cyc(1'b1, 32'h100, 32'h11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("b2b.u1.not_yet", 32'(v1), 32'd0);
    cyc(1'b1, 32'h104, 32'h22, 1'b1, 5'd1, 32'd1, 1'b1, 1'b0);
    chk("b2b.u1.latency", 32'(v1), 32'd1);
    chk("b2b.u1.first_pc", pc1, 32'h100);
    cyc(1'b1, 32'h108, 32'h33, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 32'd3, 1'b1, 1'b0);
    idle(4, 1'b1);

    cyc(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    idle(3, 1'b1);

    pulse_rst();
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 32'h5, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("ovf.u0.drop_cnt", 32'(dc0), 32'd2);
    chk("ovf.u0.overflow", 32'(ovf0), 32'd1);
    chk("ovf.u0.retire_cnt", rc0, 32'd6);
    chk("ovf.u1.drop_cnt", 32'(dc1), 32'd2);
    chk("ovf.u0.head_pc", pc0, 32'h1000);
    idle(6, 1'b1);
    chk("ovf.drained", 32'(v0), 32'd0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h2000 + 32'(4 * i), 32'h7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 32'h2010, 32'h7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("fullpop.u0.no_drop", 32'(dc0), 32'd2);
    cyc(1'b1, 32'h2014, 32'h7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("clrdrop.u0.drop_cnt", 32'(dc0), 32'd1);
    chk("clrdrop.u0.overflow", 32'(ovf0), 32'd1);
    idle(1, 1'b0);
    chk("clrdrop.u1.drop_cnt", 32'(dc1), 32'd1);
    idle(6, 1'b1);

    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 32'h9, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst.u0.out_valid", 32'(v0), 32'd0);
    chk("midrst.u1.out_valid", 32'(v1), 32'd0);
    chk("midrst.u1.retire_cnt", rc1, 32'd0);
    chk("midrst.u0.drop_cnt", 32'(dc0), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 32'h4000, 32'hA, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle(3, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60, $urandom, $urandom, $urandom_range(0, 99) < 50,
          5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 99) < 70,
          $urandom_range(0, 99) < 3);
    end
    idle(10, 1'b1);
    chk("final.u0.empty", 32'(v0), 32'd0);
    chk("final.u1.empty", 32'(v1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
